mxu_arbiter: RTL and testbench



---
 rtl/mxu_arbiter.sv | 128 ++++++++++++
 tb/tb_mxu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_arbiter.sv
// Round-robin share of one matrix multiplier: grant -> mx_in_valid in 1 cycle, result 1 cycle after finished.
// Single operation in flight; requesters stall (req_ready=0) until the tagged response is taken via resp_ready.
module mxu_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIM       = 4,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2*WIDTH+$clog2(DIM),
    parameter int TIMEOUT   = 10,
    parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]    req_b,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic [IDW-1:0]                      resp_id,
    output logic [DIM*DIM*OUT_WIDTH-1:0]        resp_y,
    output logic                                resp_timeout,
    output logic [DIM*DIM*WIDTH-1:0]            mx_in0,
    output logic [DIM*DIM*WIDTH-1:0]            mx_in1,
    output logic                                mx_in_valid,
    input  logic [DIM*DIM*OUT_WIDTH-1:0]        mx_out,
    input  logic                                mx_finished,
    output logic                                busy,
    output logic [7:0]                          err_cnt
);
    localparam int MW  = DIM*DIM*WIDTH;
    localparam int WDW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic [WDW-1:0] wd_cnt;
    logic           wd_expired;

    // Scan downward so the candidate nearest rr_ptr is the last one written.
    always_comb begin : rr_select
        logic [IDW-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Count reaches TIMEOUT on this cycle unless finished arrives alongside it.
    assign wd_expired = (wd_cnt == WDW'(TIMEOUT-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mx_finished || wd_expired) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        mx_in_valid = 1'b0;
        resp_valid  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:    if (gnt_found && !reset) req_ready[gnt_idx] = 1'b1;
            ISSUE:   mx_in_valid = 1'b1;
            RESP:    resp_valid  = 1'b1;
            default: ;
        endcase
    end

    assign resp_id = id_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            id_q         <= '0;
            mx_in0       <= '0;
            mx_in1       <= '0;
            wd_cnt       <= '0;
            resp_y       <= '0;
            resp_timeout <= 1'b0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    mx_in0 <= req_a[int'(gnt_idx)*MW +: MW];
                    mx_in1 <= req_b[int'(gnt_idx)*MW +: MW];
                    id_q   <= gnt_idx;
                    rr_ptr <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (mx_finished) begin
                        resp_y       <= mx_out;
                        resp_timeout <= 1'b0;
                    end else if (wd_expired) begin
                        resp_y       <= '0;
                        resp_timeout <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mxu_arbiter.sv
// Bench for mxu_arbiter: behavioural multiplier with programmable latency and a round-robin/err model.
module tb_mxu_arbiter;
    localparam int N   = 4;
    localparam int D   = 4;
    localparam int W   = 8;
    localparam int OW  = 2*W + $clog2(D);
    localparam int TMO = 10;
    localparam int IDW = 2;
    localparam int MW  = D*D*W;
    localparam int YW  = D*D*OW;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*MW-1:0]  req_a;
    logic [N*MW-1:0]  req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [YW-1:0]    resp_y;
    logic             resp_timeout;
    logic [MW-1:0]    mx_in0;
    logic [MW-1:0]    mx_in1;
    logic             mx_in_valid;
    logic [YW-1:0]    mx_out;
    logic             mx_finished;
    logic             busy;
    logic [7:0]       err_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [MW-1:0] op_a [N];
    logic [MW-1:0] op_b [N];
    int            m_rr = 0;
    int            m_err = 0;
    int            mx_lat = 3;
    int            cd = 0;
    logic          spur = 1'b0;
    logic [YW-1:0] mx_prod = '0;
    logic [YW-1:0] last_y;
    int            last_g;

    mxu_arbiter #(.NUM_REQ(N), .DIM(D), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_y(resp_y), .resp_timeout(resp_timeout),
        .mx_in0(mx_in0), .mx_in1(mx_in1), .mx_in_valid(mx_in_valid),
        .mx_out(mx_out), .mx_finished(mx_finished),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [YW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [YW-1:0] y;
        int unsigned   s;
        y = '0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                s = 0;
                for (int k = 0; k < D; k++)
                    s += 32'(a[(r*D+k)*W +: W]) * 32'(b[(k*D+c)*W +: W]);
                y[(r*D+c)*OW +: OW] = s[OW-1:0];
            end
        return y;
    endfunction

    // Multiplier model: finished on the mx_lat-th cycle after in_valid; mx_lat=0 never finishes.
    always @(posedge clk) begin
        if (mx_in_valid) begin
            cd      <= mx_lat;
            mx_prod <= matmul(mx_in0, mx_in1);
        end else if (cd > 0) begin
            cd <= cd - 1;
        end
    end
    assign mx_finished = spur || (cd == 1);
    assign mx_out      = mx_prod;

    task automatic chk(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_rr+k)%N]) return (m_rr+k)%N;
        return 0;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*MW +: MW] = op_a[i];
            req_b[i*MW +: MW] = op_b[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++)
            for (int e = 0; e < D*D; e++) begin
                op_a[i][e*W +: W] = W'($urandom);
                op_b[i][e*W +: W] = W'($urandom);
            end
        pack_ops();
    endtask

    task automatic do_txn(input logic [N-1:0] vmask, input int lat, input int hold);
        int            g;
        int            n;
        logic          tmo;
        logic [N-1:0]  oh;
        logic [YW-1:0] exp_y;
        mx_lat     = lat;
        tmo        = (lat == 0) || (lat > TMO);
        resp_ready = (hold == 0);
        req_valid  = vmask;
        #1;
        g = model_grant(vmask);
        oh = '0; oh[g] = 1'b1;
        chk("grant", req_ready, oh);
        @(posedge clk); #1;
        req_valid = '0;
        m_rr = (g + 1) % N;
        chk("issue_vld", mx_in_valid, 1);
        chk("issue_rdy", req_ready, 0);
        chk("issue_busy", busy, 1);
        chk("issue_in0", mx_in0, op_a[g]);
        chk("issue_in1", mx_in1, op_b[g]);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("wait_vld", mx_in_valid, 0);
        end while (!resp_valid && n < 60);
        chk("resp_lat", n, tmo ? TMO+1 : lat+1);
        exp_y = tmo ? '0 : matmul(op_a[g], op_b[g]);
        if (tmo && m_err < 255) m_err++;
        chk("resp_id", resp_id, g);
        chk("resp_y", resp_y, exp_y);
        chk("resp_tmo", resp_timeout, tmo);
        chk("resp_busy", busy, 1);
        chk("err_cnt", err_cnt, m_err);
        if (hold > 0) begin
            req_valid = vmask;
            for (int i = 0; i < hold; i++) begin
                chk("hold_vld", resp_valid, 1);
                chk("hold_y", resp_y, exp_y);
                chk("hold_id", resp_id, g);
                chk("hold_rdy", req_ready, 0);
                chk("hold_busy", busy, 1);
                @(posedge clk); #1;
            end
            resp_ready = 1'b1;
        end
        last_y = resp_y;
        last_g = g;
        @(posedge clk); #1;
        chk("after_vld", resp_valid, 0);
        chk("after_busy", busy, 0);
        if (hold > 0) begin
            oh = '0; oh[model_grant(vmask)] = 1'b1;
            chk("regrant", req_ready, oh);
            req_valid = '0;
        end
    endtask

    initial begin
        logic [YW-1:0] b_wide;
        int            start;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        #1 reset = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", req_ready, 0);
        chk("rst_rvld", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mxv", mx_in_valid, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_in0", mx_in0, 0);
        chk("rst_y", resp_y, 0);
        req_valid = '0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single request: identity times B returns B widened.
        rand_ops();
        b_wide = '0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                op_a[0][(r*D+c)*W +: W] = (r == c) ? W'(1) : W'(0);
                op_b[0][(r*D+c)*W +: W] = W'(r*4 + c);
                b_wide[(r*D+c)*OW +: OW] = OW'(r*4 + c);
            end
        pack_ops();
        do_txn(4'b0001, 3, 0);
        chk("single_y", last_y, b_wide);
        chk("single_id", last_g, 0);

        // Round robin with all requesters active.
        start = m_rr;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            do_txn(4'b1111, $urandom_range(1, 9), 0);
            chk("rr_order", last_g, (start + i) % N);
        end

        rand_ops();
        do_txn(4'b0110, 4, 20);

        for (int i = 0; i < 20; i++) begin
            rand_ops();
            do_txn(N'($urandom_range(1, 15)), $urandom_range(1, 9), $urandom_range(0, 3));
        end

        rand_ops();
        do_txn(4'b1111, 0, 0);
        chk("first_tmo_err", err_cnt, 1);
        do_txn(4'b1010, TMO, 0);
        chk("boundary_err", err_cnt, 1);
        do_txn(4'b0101, TMO+1, 0);

        // Spurious finished in IDLE must be ignored.
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("spur_vld", resp_valid, 0);
            chk("spur_busy", busy, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 300; i++)
            do_txn(N'($urandom_range(1, 15)), 0, 0);
        chk("err_sat", err_cnt, 255);

        // Reset in the middle of WAIT, asserted between edges.
        mx_lat = 0;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mrst_rdy", req_ready, 0);
        chk("mrst_rvld", resp_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_mxv", mx_in_valid, 0);
        chk("mrst_err", err_cnt, 0);
        chk("mrst_in0", mx_in0, 0);
        chk("mrst_tmo", resp_timeout, 0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        m_rr  = 0;
        m_err = 0;
        @(posedge clk); #1;
        rand_ops();
        do_txn(4'b1111, 2, 0);
        chk("post_rst_grant", last_g, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
